// File: rtl/rgbw_srx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rgbw_srx
// Purpose  : SK6812 RGBW single-wire stream receiver. Measures high/low pulse
//            widths of the synchronised input, decodes MSB-first 32-bit words,
//            and flags stream resets (long low) and malformed frames
//            (partial word at a stream reset, or a stuck-high line).
// Ports    : clk              system clock (96 MHz nominal)
//            rst              asynchronous active-low reset
//            sig              asynchronous serial RGBW input
//            out_word         last completed word, MSB = first bit received
//            out_strobe       1-cycle pulse, out_word newly valid
//            out_stream_reset 1-cycle pulse, stream reset detected
//            out_frame_error  1-cycle pulse, partial word dropped / stuck high
//            out_word_count   words since last stream reset, saturating
// Revision : 1.0 - initial release
// ============================================================================
module rgbw_srx #(
  parameter int SAMPLE_TIME_CLKS  = 30,
  parameter int MIN_HIGH_CLKS     = 4,
  parameter int STREAM_RESET_CLKS = 4800,
  parameter int MAX_HIGH_CLKS     = 120,
  parameter int COUNTER_MAX       = 7800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig,
  output logic [31:0] out_word,
  output logic        out_strobe,
  output logic        out_stream_reset,
  output logic        out_frame_error,
  output logic [15:0] out_word_count
);

  localparam int                 c_cnt_w    = $clog2(COUNTER_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(COUNTER_MAX);
  localparam logic [c_cnt_w-1:0] c_sample   = c_cnt_w'(SAMPLE_TIME_CLKS);
  localparam logic [c_cnt_w-1:0] c_min_high = c_cnt_w'(MIN_HIGH_CLKS);
  localparam logic [c_cnt_w-1:0] c_max_high = c_cnt_w'(MAX_HIGH_CLKS);
  localparam logic [c_cnt_w-1:0] c_sreset   = c_cnt_w'(STREAM_RESET_CLKS);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_SYNC_WAIT = 2'd0,
    S_IDLE      = 2'd1,
    S_HIGH      = 2'd2,
    S_LOW       = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_sync1;
  logic               r_sig_s;
  logic               r_sig_prev;
  logic [c_cnt_w-1:0] r_cnt;
  logic [31:0]        r_shift;
  logic [31:0]        r_word;
  logic [4:0]         r_bits;
  logic [15:0]        r_wcount;
  logic               r_strobe;
  logic               r_sreset;
  logic               r_ferr;

  logic               w_rise;
  logic               w_fall;
  logic               w_low_done;
  logic               w_stuck;
  logic               w_bit;
  logic               w_shift_en;
  logic               w_clear_bits;
  logic               w_sreset;
  logic               w_ferr;
  logic               w_complete;
  logic [31:0]        w_shifted;

  // r_cnt always describes the level held in r_sig_prev: the number of
  // consecutive cycles that level lasted up to the previous cycle. On an edge
  // of r_sig_s it therefore still holds the full width of the pulse just ended.
  assign w_rise     = r_sig_s & ~r_sig_prev;
  assign w_fall     = ~r_sig_s & r_sig_prev;
  // r_cnt steps through the threshold once per low period (it saturates far
  // above it), so this fires exactly once however long the line stays low.
  assign w_low_done = ~r_sig_prev && (r_cnt == c_sreset);
  assign w_stuck    = r_sig_prev && (r_cnt >= c_max_high);
  assign w_bit      = (r_cnt >= c_sample);
  assign w_shifted  = {r_shift[30:0], w_bit};
  assign w_complete = w_shift_en && (r_bits == 5'd31);

  // Synchroniser and width counter. The line is treated as high during
  // reset, so a low seen after release is timed exactly like a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= 1'b1;
      r_sig_s    <= 1'b1;
      r_sig_prev <= 1'b1;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= sig;
      r_sig_s    <= r_sync1;
      r_sig_prev <= r_sig_s;
      if (r_sig_s != r_sig_prev) begin
        r_cnt <= c_cnt_one;
      end else if (r_cnt != c_cnt_max) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_SYNC_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_shift_en   = 1'b0;
    w_clear_bits = 1'b0;
    w_sreset     = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      S_SYNC_WAIT: begin
        if (w_low_done) begin
          w_sreset = 1'b1;
          w_next   = w_rise ? S_HIGH : S_IDLE;
        end
      end
      S_IDLE: begin
        if (w_rise) begin
          w_next = S_HIGH;
        end
      end
      S_HIGH: begin
        if (w_stuck) begin
          w_ferr       = 1'b1;
          w_clear_bits = 1'b1;
          w_next       = S_SYNC_WAIT;
        end else if (w_fall) begin
          // Pulses shorter than the glitch limit leave the word untouched.
          w_shift_en = (r_cnt >= c_min_high);
          w_next     = S_LOW;
        end
      end
      S_LOW: begin
        // The stream-reset test goes first so a rise landing on the very
        // cycle the low period qualifies does not swallow the reset.
        if (w_low_done) begin
          w_sreset     = 1'b1;
          w_ferr       = (r_bits != 5'd0);
          w_clear_bits = 1'b1;
          w_next       = w_rise ? S_HIGH : S_IDLE;
        end else if (w_rise) begin
          w_next = S_HIGH;
        end
      end
      default: w_next = S_SYNC_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift  <= '0;
      r_bits   <= '0;
      r_word   <= '0;
      r_wcount <= '0;
      r_strobe <= 1'b0;
      r_sreset <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_strobe <= w_complete;
      r_sreset <= w_sreset;
      r_ferr   <= w_ferr;
      if (w_clear_bits) begin
        r_bits <= '0;
      end else if (w_shift_en) begin
        r_shift <= w_shifted;
        r_bits  <= w_complete ? 5'd0 : r_bits + 5'd1;
      end
      if (w_complete) begin
        r_word <= w_shifted;
      end
      if (w_sreset) begin
        r_wcount <= '0;
      end else if (w_complete && (r_wcount != 16'hFFFF)) begin
        r_wcount <= r_wcount + 16'd1;
      end
    end
  end

  assign out_word         = r_word;
  assign out_strobe       = r_strobe;
  assign out_stream_reset = r_sreset;
  assign out_frame_error  = r_ferr;
  assign out_word_count   = r_wcount;

endmodule
`default_nettype wire

// File: tb/tb_rgbw_srx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rgbw_srx
// Purpose  : Directed self-checking bench for rgbw_srx. Drives SK6812 bit
//            timings on sig and checks decoded words, pulse timing, stream
//            reset, frame errors, glitch rejection and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgbw_srx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sig = 1'b0;
  logic [31:0] out_word;
  logic        out_strobe;
  logic        out_stream_reset;
  logic        out_frame_error;
  logic [15:0] out_word_count;

  rgbw_srx dut (
    .clk              (clk),
    .rst              (rst),
    .sig              (sig),
    .out_word         (out_word),
    .out_strobe       (out_strobe),
    .out_stream_reset (out_stream_reset),
    .out_frame_error  (out_frame_error),
    .out_word_count   (out_word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // Event log, sampled on the falling edge away from the active edge.
  int          n_strobe  = 0;
  int          n_sreset  = 0;
  int          n_ferr    = 0;
  int          strobe_cyc = -1;
  int          sreset_cyc = -1;
  int          ferr_cyc   = -1;
  logic [31:0] word_q[$];
  logic [15:0] wcnt_q[$];

  always @(negedge clk) begin
    if (out_strobe === 1'b1) begin
      n_strobe++;
      strobe_cyc = cyc;
      word_q.push_back(out_word);
      wcnt_q.push_back(out_word_count);
    end
    if (out_stream_reset === 1'b1) begin
      n_sreset++;
      sreset_cyc = cyc;
    end
    if (out_frame_error === 1'b1) begin
      n_ferr++;
      ferr_cyc = cyc;
    end
  end

  int last_fall = 0;

  // Level changes land 1 ns after a rising edge; cyc then equals the index of
  // that edge, so a pin event at cyc=e shows on the outputs at cyc=e+3.
  task automatic drive(input logic lvl, input int n);
    sig = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int low_len);
    drive(1'b1, b ? 45 : 16);
    last_fall = cyc;
    drive(1'b0, (low_len != 0) ? low_len : (b ? 45 : 74));
  endtask

  task automatic send_word(input logic [31:0] w, input int tail);
    for (int i = 31; i >= 0; i--) send_bit(w[i], (i == 0) ? tail : 0);
  endtask

  task automatic clear_log();
    word_q.delete();
    wcnt_q.delete();
  endtask

  task automatic test_reset();
    int e0;
    rst = 1'b0;
    sig = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (out_word !== 32'h0) begin miscompares++; $display("FAIL reset_word got %h want 00000000", out_word); end
    vectors++; if (out_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_strobe got %b want 0", out_strobe); end
    vectors++; if (out_stream_reset !== 1'b0) begin miscompares++; $display("FAIL reset_sreset got %b want 0", out_stream_reset); end
    vectors++; if (out_frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_ferr got %b want 0", out_frame_error); end
    vectors++; if (out_word_count !== 16'h0) begin miscompares++; $display("FAIL reset_count got %h want 0000", out_word_count); end
    rst = 1'b1;
    e0  = cyc;
    drive(1'b0, 5000);
    vectors++; if (n_sreset !== 1) begin miscompares++; $display("FAIL sync_sreset_count got %0d want 1", n_sreset); end
    vectors++; if (sreset_cyc !== e0 + 4803) begin miscompares++; $display("FAIL sync_sreset_cycle got %0d want %0d", sreset_cyc, e0 + 4803); end
    vectors++; if (n_strobe !== 0) begin miscompares++; $display("FAIL sync_no_strobe got %0d want 0", n_strobe); end
    vectors++; if (n_ferr !== 0) begin miscompares++; $display("FAIL sync_no_ferr got %0d want 0", n_ferr); end
  endtask

  task automatic test_word_decode();
    int s0, r0, f0;
    logic [31:0] got_w;
    logic [15:0] got_c;
    s0 = n_strobe; r0 = n_sreset; f0 = n_ferr;
    clear_log();
    send_word(32'h12345678, 7681);
    got_w = (word_q.size() > 0) ? word_q[0] : 32'hx;
    got_c = (wcnt_q.size() > 0) ? wcnt_q[0] : 16'hx;
    vectors++; if (n_strobe !== s0 + 1) begin miscompares++; $display("FAIL decode_strobes got %0d want %0d", n_strobe - s0, 1); end
    vectors++; if (strobe_cyc !== last_fall + 3) begin miscompares++; $display("FAIL decode_strobe_cycle got %0d want %0d", strobe_cyc, last_fall + 3); end
    vectors++; if (got_w !== 32'h12345678) begin miscompares++; $display("FAIL decode_word got %h want 12345678", got_w); end
    vectors++; if (got_c !== 16'd1) begin miscompares++; $display("FAIL decode_count got %0d want 1", got_c); end
    vectors++; if (n_sreset !== r0 + 1) begin miscompares++; $display("FAIL decode_sreset got %0d want 1", n_sreset - r0); end
    vectors++; if (sreset_cyc !== last_fall + 4803) begin miscompares++; $display("FAIL decode_sreset_cycle got %0d want %0d", sreset_cyc, last_fall + 4803); end
    vectors++; if (out_word_count !== 16'd0) begin miscompares++; $display("FAIL decode_count_cleared got %0d want 0", out_word_count); end
    vectors++; if (out_word !== 32'h12345678) begin miscompares++; $display("FAIL decode_word_held got %h want 12345678", out_word); end
    vectors++; if (n_ferr !== f0) begin miscompares++; $display("FAIL decode_no_ferr got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w[3];
    exp_w = '{32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5};
    clear_log();
    send_word(exp_w[0], 0);
    send_word(exp_w[1], 0);
    send_word(exp_w[2], 5000);
    vectors++; if (word_q.size() !== 3) begin miscompares++; $display("FAIL b2b_strobes got %0d want 3", word_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < word_q.size()) begin
        vectors++; if (word_q[i] !== exp_w[i]) begin miscompares++; $display("FAIL b2b_word%0d got %h want %h", i, word_q[i], exp_w[i]); end
        vectors++; if (wcnt_q[i] !== 16'(i + 1)) begin miscompares++; $display("FAIL b2b_count%0d got %0d want %0d", i, wcnt_q[i], i + 1); end
      end
    end
  endtask

  task automatic test_partial_frame();
    int s0, r0, f0;
    logic [9:0] pat;
    pat = 10'b1011001110;
    s0 = n_strobe; r0 = n_sreset; f0 = n_ferr;
    clear_log();
    for (int i = 9; i >= 0; i--) send_bit(pat[i], (i == 0) ? 7681 : 0);
    vectors++; if (n_ferr !== f0 + 1) begin miscompares++; $display("FAIL partial_ferr got %0d want 1", n_ferr - f0); end
    vectors++; if (n_sreset !== r0 + 1) begin miscompares++; $display("FAIL partial_sreset got %0d want 1", n_sreset - r0); end
    vectors++; if (ferr_cyc !== sreset_cyc) begin miscompares++; $display("FAIL partial_same_cycle got ferr %0d sreset %0d", ferr_cyc, sreset_cyc); end
    vectors++; if (sreset_cyc !== last_fall + 4803) begin miscompares++; $display("FAIL partial_sreset_cycle got %0d want %0d", sreset_cyc, last_fall + 4803); end
    vectors++; if (n_strobe !== s0) begin miscompares++; $display("FAIL partial_no_strobe got %0d want 0", n_strobe - s0); end
    send_word(32'hDEADBEEF, 5000);
    vectors++; if (word_q.size() !== 1) begin miscompares++; $display("FAIL partial_next_strobes got %0d want 1", word_q.size()); end
    vectors++; if (out_word !== 32'hDEADBEEF) begin miscompares++; $display("FAIL partial_next_word got %h want deadbeef", out_word); end
    vectors++; if (n_ferr !== f0 + 1) begin miscompares++; $display("FAIL partial_next_ferr got %0d want 1", n_ferr - f0); end
  endtask

  task automatic test_glitch();
    int f0;
    logic [31:0] w;
    logic b;
    int lo;
    w  = 32'h0F0F1234;
    f0 = n_ferr;
    clear_log();
    for (int i = 31; i >= 0; i--) begin
      b = w[i];
      if (i == 20) begin
        lo = b ? 45 : 74;
        drive(1'b1, b ? 45 : 16);
        drive(1'b0, 20);
        drive(1'b1, 2);
        drive(1'b0, lo - 22);
      end else begin
        send_bit(b, (i == 0) ? 5000 : 0);
      end
    end
    vectors++; if (word_q.size() !== 1) begin miscompares++; $display("FAIL glitch_strobes got %0d want 1", word_q.size()); end
    vectors++; if (out_word !== 32'h0F0F1234) begin miscompares++; $display("FAIL glitch_word got %h want 0f0f1234", out_word); end
    vectors++; if (n_ferr !== f0) begin miscompares++; $display("FAIL glitch_no_ferr got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_stuck_high();
    int s0, r0, f0, e0;
    s0 = n_strobe; r0 = n_sreset; f0 = n_ferr;
    e0 = cyc;
    drive(1'b1, 200);
    drive(1'b0, 50);
    send_word(32'h13579BDF, 5000);
    vectors++; if (n_ferr !== f0 + 1) begin miscompares++; $display("FAIL stuck_ferr got %0d want 1", n_ferr - f0); end
    vectors++; if (ferr_cyc !== e0 + 123) begin miscompares++; $display("FAIL stuck_ferr_cycle got %0d want %0d", ferr_cyc, e0 + 123); end
    vectors++; if (n_strobe !== s0) begin miscompares++; $display("FAIL stuck_ignored got %0d want 0", n_strobe - s0); end
    vectors++; if (n_sreset !== r0 + 1) begin miscompares++; $display("FAIL stuck_sreset got %0d want 1", n_sreset - r0); end
    vectors++; if (sreset_cyc !== last_fall + 4803) begin miscompares++; $display("FAIL stuck_sreset_cycle got %0d want %0d", sreset_cyc, last_fall + 4803); end
  endtask

  task automatic test_async_reset();
    int s0, r0;
    logic [31:0] w;
    w  = 32'hF0E1D2C3;
    s0 = n_strobe;
    for (int i = 31; i >= 15; i--) send_bit(w[i], 0);
    sig = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    vectors++; if (out_word !== 32'h0) begin miscompares++; $display("FAIL arst_word got %h want 00000000", out_word); end
    vectors++; if (out_strobe !== 1'b0) begin miscompares++; $display("FAIL arst_strobe got %b want 0", out_strobe); end
    vectors++; if (out_stream_reset !== 1'b0) begin miscompares++; $display("FAIL arst_sreset got %b want 0", out_stream_reset); end
    vectors++; if (out_frame_error !== 1'b0) begin miscompares++; $display("FAIL arst_ferr got %b want 0", out_frame_error); end
    vectors++; if (out_word_count !== 16'h0) begin miscompares++; $display("FAIL arst_count got %h want 0000", out_word_count); end
    repeat (3) @(posedge clk);
    #1;
    sig = 1'b0;
    rst = 1'b1;
    clear_log();
    r0 = n_sreset;
    drive(1'b0, 20);
    send_word(32'h89ABCDEF, 5000);
    vectors++; if (n_strobe !== s0) begin miscompares++; $display("FAIL arst_ignored got %0d want 0", n_strobe - s0); end
    vectors++; if (n_sreset !== r0 + 1) begin miscompares++; $display("FAIL arst_sreset got %0d want 1", n_sreset - r0); end
    vectors++; if (sreset_cyc !== last_fall + 4803) begin miscompares++; $display("FAIL arst_sreset_cycle got %0d want %0d", sreset_cyc, last_fall + 4803); end
    send_word(32'h3C3C3C3C, 5000);
    vectors++; if (word_q.size() !== 1) begin miscompares++; $display("FAIL arst_next_strobes got %0d want 1", word_q.size()); end
    vectors++; if (out_word !== 32'h3C3C3C3C) begin miscompares++; $display("FAIL arst_next_word got %h want 3c3c3c3c", out_word); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_word_decode();
    test_back_to_back();
    test_partial_frame();
    test_glitch();
    test_stuck_high();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgbw_srx.md
Name: rgbw_srx

Overview:
- Serial receiver/decoder for the SK6812 RGBW single-wire stream produced by rgb_sotp.
- Measures high/low pulse widths, assembles MSB-first 32-bit words, and flags stream resets and malformed frames.
- Used for on-chip loopback checking of the rgb_sotp output, and as the front end of a future RGBW pass-through path.

Parameters:
- SAMPLE_TIME_CLKS, 30: high-time threshold in clocks; a high time >= this decodes as 1, otherwise 0.
- MIN_HIGH_CLKS, 4: high pulses shorter than this are glitches and are ignored.
- STREAM_RESET_CLKS, 4800: low-time in clocks that constitutes a stream reset.
- MAX_HIGH_CLKS, 120: high time reaching this is a stuck-high error.
- COUNTER_MAX, 7800: saturation value of the pulse-width counter; also sets its width as clog2(COUNTER_MAX+1).

Ports:
- clk  in  1  system clock (96 MHz nominal)
- rst  in  1  asynchronous, active-low reset
- sig  in  1  asynchronous serial RGBW input
- out_word  out  32  last completed word, MSB = first bit received
- out_strobe  out  1  one-cycle pulse: out_word newly valid
- out_stream_reset  out  1  one-cycle pulse: stream reset detected
- out_frame_error  out  1  one-cycle pulse: partial word discarded, or stuck-high
- out_word_count  out  16  words received since the last stream reset; saturates at 16'hFFFF

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, shift register and bit count 0, state SYNC_WAIT.
- Input synchronizer: sig passes through 2 flops to give sig_s. All decisions use sig_s.
- Latency: out_strobe, out_stream_reset and out_frame_error are registered and assert 3 clk after the triggering edge at the sig pin.
- cnt: saturating width counter. It loads 1 on the first cycle of each new sig_s level and increments each cycle the level holds, capped at COUNTER_MAX.
- State SYNC_WAIT: ignore data. When sig_s has been low with cnt == STREAM_RESET_CLKS, pulse out_stream_reset and go to IDLE.
  - Rationale: the receiver never decodes mid-stream after reset.
- State IDLE: on rising sig_s go to HIGH.
- State HIGH:
  - If cnt reaches MAX_HIGH_CLKS: pulse out_frame_error, clear bit count, go to SYNC_WAIT.
  - On falling sig_s with cnt < MIN_HIGH_CLKS: glitch; no bit is recorded; go to LOW.
  - On falling sig_s otherwise: shift in bit = (cnt >= SAMPLE_TIME_CLKS), increment bit count, go to LOW.
- State LOW:
  - Rising sig_s returns to HIGH.
  - If cnt == STREAM_RESET_CLKS: pulse out_stream_reset and clear out_word_count.
    - If bit count != 0, also pulse out_frame_error and discard the partial word (bit count to 0).
    - Then go to IDLE.
- Word completion: when the 32nd bit shifts in, in the same cycle:
  - out_word <= full shift value (new bit in LSB);
  - pulse out_strobe;
  - bit count <= 0;
  - out_word_count increments, saturating.
- out_word holds its value until the next completion. It is not cleared by stream reset.
- Simultaneous events: the 32nd bit completing and a stream reset cannot coincide, because they are separated by at least one clock of low.
- Counter saturation: cnt never wraps. A low held beyond COUNTER_MAX produces no second out_stream_reset; exactly one pulse per low period.
- Idle line: a line held low indefinitely gives one out_stream_reset only.

Test Plan:
- Startup sync: release rst, hold sig low 5000 clk -> one out_stream_reset pulse at cycle 4800+3 of low; no other pulses.
- Word decode: after sync, drive 0x12345678 MSB-first (1-bit 45H/45L, 0-bit 16H/74L), then 7681 low. Required response:
  - out_strobe once, 3 clk after the final falling edge;
  - out_word = 0x12345678;
  - out_word_count = 1, then cleared to 0 by out_stream_reset.
- Back-to-back: words 0xFFFFFFFF, 0x00000000, 0xA5A5A5A5 with no gaps -> three strobes with exactly those values, in order; out_word_count reaches 3.
- Partial frame: 10 bits, then 7681 low -> out_frame_error and out_stream_reset in the same cycle; no out_strobe; bit count cleared. A following full word 0xDEADBEEF decodes correctly.
- Glitch and stuck-high:
  - A 2-clk high pulse mid-word is ignored; the word still decodes correctly.
  - sig held high 200 clk -> out_frame_error at high-cycle 120+3; new data is ignored until 4800 low clocks give out_stream_reset.
- Async reset mid-word: assert rst after 17 bits -> all outputs 0 immediately with no clk edge; after release, data is ignored until a 4800-clk low.
